color_spi_rx: RTL

COLOR_SPI_RX -- requirements
Module: color_spi_rx

---
 rtl/color_spi_rx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/color_spi_rx.sv
// color_spi_rx: receives a GRB colour string over a slave-only SPI link
// (sck/sdi/cs_n from an MCU) and presents the last complete frame to the LED
// shifter. SPI pins are resynchronised into the clk domain. A frame is
// accepted only if exactly 24*N_LEDS bits arrive while cs_n is low.
module color_spi_rx #(
    parameter int          N_LEDS        = 6,
    parameter logic [23:0] DEFAULT_COLOR = 24'h000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sck,
    input  logic                 sdi,
    input  logic                 cs_n,
    output logic [24*N_LEDS-1:0] color_string,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int FRAME_BITS = 24 * N_LEDS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Synchronizer chains: meta -> sync, plus a delayed copy for edge detection.
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic sdi_meta_q, sdi_sync_q;
    logic cs_meta_q,  cs_sync_q,  cs_prev_q;

    state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] color_q, color_d;
    logic                  valid_q, valid_d;
    logic                  err_q,   err_d;

    logic sck_rise;
    logic cs_fall;
    logic cs_rise;

    // Two-flop synchronizers plus one delay stage for the edge detectors.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            sdi_meta_q <= 1'b0;
            sdi_sync_q <= 1'b0;
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            cs_prev_q  <= 1'b1;
        end else begin
            sck_meta_q <= sck;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
            sdi_meta_q <= sdi;
            sdi_sync_q <= sdi_meta_q;
            cs_meta_q  <= cs_n;
            cs_sync_q  <= cs_meta_q;
            cs_prev_q  <= cs_sync_q;
        end
    end

    assign sck_rise = sck_sync_q  & ~sck_prev_q;
    assign cs_fall  = ~cs_sync_q  &  cs_prev_q;
    assign cs_rise  = cs_sync_q   & ~cs_prev_q;

    // State register and datapath registers.
    // NOTE: the shift register is a plain flop array, not a RAM, so clearing
    // it on reset costs nothing beyond the reset mux on each bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            color_q <= {N_LEDS{DEFAULT_COLOR}};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            color_q <= color_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: cs_n edges alone delimit a frame.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = RECV;
            RECV:    if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: shift bits while receiving, then accept or
    // reject the frame on the closing cs_n edge. A cs_n rise masks an sck
    // rise seen in the same cycle.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        color_d = color_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) cnt_d = '0;
            end
            RECV: begin
                if (cs_rise) begin
                    if (cnt_q == CNT_FULL) begin
                        color_d = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sck_rise) begin
                    if (cnt_q < CNT_FULL) shift_d = {shift_q[FRAME_BITS-2:0], sdi_sync_q};
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign color_string = color_q;
    assign frame_valid  = valid_q;
    assign frame_err    = err_q;
    assign busy         = (state_q == RECV);

endmodule
